data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the MIPS32 data memory controller's request interface.
- Accepts the controller's level-held read enable or 4-bit byte write enables, and services them against an internal word-addressed RAM after a programmable number of wait states.
- Returns read data and a one-cycle ready pulse that releases the MEM-stage stall.
- Sits between the MEM-stage controller and on-chip data storage; all endian and lane steering stays on the controller side.

Parameters:
- ADDR_WIDTH, 10, word-address width; RAM depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles between request acceptance and ready. Legal range 0..15.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the controller; bits [1:0] are ignored.
- MWriteData  input  32  write data, already lane-steered by the controller.
- WriteEnable  input  4  per-byte write enables: [3] covers bits 31:24, [0] covers bits 7:0.
- ReadEnable  input  1  read request.
- MReadData  output  32  registered read data.
- DataMem_Ready  output  1  one-cycle completion pulse.
- BusError  output  1  pulses together with ready when the access was out of range.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; DataMem_Ready = 0; BusError = 0; MReadData = 0; wait counter = 0.
  - RAM contents are not cleared.
- Request:
  - A request is present when ReadEnable = 1 or WriteEnable != 0.
  - The requester holds the request level until it sees ready. It drops the request within one cycle after the ready pulse.
- IDLE:
  - On a request, capture the following into internal registers:
    - word index = Address[ADDR_WIDTH+1:2];
    - range flag = (Address[31:ADDR_WIDTH+2] != 0);
    - MWriteData, WriteEnable and the operation type.
  - Then go to BUSY with counter = WAIT_STATES, or go directly to ACCESS when WAIT_STATES = 0.
  - Simultaneous read and write: treat it as a write only; MReadData is unchanged.
- BUSY:
  - Decrement the counter each cycle; go to ACCESS when the counter reaches 1.
  - Live inputs are ignored; only the captured copies are used.
- ACCESS (one cycle; performs the access at the end of the cycle):
  - Write, in range: update only the enabled bytes of RAM[index].
  - Read, in range: MReadData <= RAM[index].
  - Out of range: no RAM change; a read loads MReadData <= 0; BusError is set.
  - Set DataMem_Ready; go to ACK.
- ACK:
  - DataMem_Ready = 1 for exactly this cycle; BusError is valid in the same cycle.
  - The still-asserted request is not re-accepted.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 → ready high in cycle 2 + WAIT_STATES.
  - WAIT_STATES = 0 gives ready in cycle 2.
- MReadData holds its value through and after the ready pulse until the next completed read. The controller consumes it one or more cycles after ready.
- DataMem_Ready and BusError are 0 in every state except ACK.
- A read following a write to the same word returns the merged new data. No bypass is needed because accesses are serialized.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; no ready is issued.
  - A captured write not yet in ACCESS is discarded.
- Counter width is 4 bits; WAIT_STATES values above 15 are unsupported.

Test Plan:
1. WAIT_STATES=1: write 0xDEADBEEF, WriteEnable=1111, Address=0x40, then read 0x40 → ready 3 cycles after each request is sampled; MReadData = 0xDEADBEEF, held after ready.
2. Byte merge: write 0x11223344 with WriteEnable=1111, then 0xAAxxxxxx with WriteEnable=1000 and 0xxxxxBBxx with WriteEnable=0010 to the same word → read returns 0xAA22BB44.
3. Held request: keep ReadEnable high for 6 cycles with WAIT_STATES=0 → exactly one ready pulse per acceptance; not re-accepted in the ACK cycle.
4. Out of range: ADDR_WIDTH=10, read Address=0x0000_1000 → ready with BusError=1 and MReadData=0. Writing 0x1000 with WriteEnable=1111 leaves RAM[0] unchanged.
5. Reset mid-op: WAIT_STATES=3, issue a write to 0x8, assert reset in BUSY → no ready, state IDLE; a later read of 0x8 returns the old contents.
6. Simultaneous ReadEnable=1 and WriteEnable=0011 → write performed; MReadData unchanged; single ready pulse.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM-stage data memory controller and its
// memory-side responder.
interface data_mem_responder_if;
  logic [31:0] Address;
  logic [31:0] MWriteData;
  logic [3:0]  WriteEnable;
  logic        ReadEnable;
  logic [31:0] MReadData;
  logic        DataMem_Ready;
  logic        BusError;

  modport master (
    output Address, MWriteData, WriteEnable, ReadEnable,
    input  MReadData, DataMem_Ready, BusError
  );

  modport slave (
    input  Address, MWriteData, WriteEnable, ReadEnable,
    output MReadData, DataMem_Ready, BusError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM responder: captures a held request, waits WAIT_STATES
// cycles, performs the access, then pulses DataMem_Ready for one cycle.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam int          HI_W      = 30 - ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic                    req_s, capture_s;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic                    oor_r;
  logic                    is_wr_r;
  logic [31:0]             wdata_r;
  logic [3:0]              we_r;
  logic [31:0]             rdata_r;
  logic                    ready_r;
  logic                    berr_r;
  logic [31:0]             mem_r [0:DEPTH-1];

  // A request is a held read level or any nonzero byte-write mask.
  always_comb begin
    req_s = bus.ReadEnable | (bus.WriteEnable != 4'b0000);
  end

  // Next-state logic; the counter only advances while in BUSY.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          capture_s = 1'b1;
          if (WAIT_INIT == 4'd0) begin
            state_s = ACCESS;
          end else begin
            state_s = BUSY;
            cnt_s   = WAIT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = (cnt_r != 4'd0) ? (cnt_r - 4'd1) : 4'd0;
        if (cnt_r <= 4'd1) begin
          state_s = ACCESS;
        end else begin
          state_s = BUSY;
        end
      end
      ACCESS:  state_s = ACK;
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, captured request copy and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= {ADDR_WIDTH{1'b0}};
      oor_r   <= 1'b0;
      is_wr_r <= 1'b0;
      wdata_r <= 32'd0;
      we_r    <= 4'd0;
      rdata_r <= 32'd0;
      ready_r <= 1'b0;
      berr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        idx_r   <= bus.Address[ADDR_WIDTH+1:2];
        oor_r   <= (bus.Address[31:ADDR_WIDTH+2] != {HI_W{1'b0}});
        is_wr_r <= (bus.WriteEnable != 4'b0000);
        wdata_r <= bus.MWriteData;
        we_r    <= bus.WriteEnable;
      end
      ready_r <= (state_r == ACCESS);
      berr_r  <= (state_r == ACCESS) && oor_r;
      // A write that also carried ReadEnable leaves the read data untouched.
      if ((state_r == ACCESS) && !is_wr_r) begin
        rdata_r <= oor_r ? 32'd0 : mem_r[idx_r];
      end
    end
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge clock) begin
    if ((state_r == ACCESS) && is_wr_r && !oor_r) begin
      for (int b = 0; b < 4; b++) begin
        if (we_r[b]) begin
          mem_r[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  assign bus.MReadData     = rdata_r;
  assign bus.DataMem_Ready = ready_r;
  assign bus.BusError      = berr_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states) share one driver;
// a monitor pops expected responses whenever a ready pulse appears.
module tb_data_mem_responder;

  localparam int D0 = 0;  // WAIT_STATES = 0
  localparam int D1 = 1;  // WAIT_STATES = 1
  localparam int D3 = 2;  // WAIT_STATES = 3

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] rd;
    logic        be;
  } exp_t;

  logic        clock;
  logic        reset;
  int          sel;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [3:0]  we_s;
  logic        re_s;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic        hold_pend = 1'b0;
  int          hold_dut = 0;
  logic [31:0] hold_val = 32'd0;

  logic [2:0]  rdy_s;
  logic [2:0]  be_s;
  logic [31:0] rd_s [3];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus3 ();

  assign bus0.Address = addr_s;  assign bus0.MWriteData = wdata_s;
  assign bus1.Address = addr_s;  assign bus1.MWriteData = wdata_s;
  assign bus3.Address = addr_s;  assign bus3.MWriteData = wdata_s;
  assign bus0.ReadEnable  = (sel == D0) ? re_s : 1'b0;
  assign bus1.ReadEnable  = (sel == D1) ? re_s : 1'b0;
  assign bus3.ReadEnable  = (sel == D3) ? re_s : 1'b0;
  assign bus0.WriteEnable = (sel == D0) ? we_s : 4'b0000;
  assign bus1.WriteEnable = (sel == D1) ? we_s : 4'b0000;
  assign bus3.WriteEnable = (sel == D3) ? we_s : 4'b0000;

  assign rdy_s = {bus3.DataMem_Ready, bus1.DataMem_Ready, bus0.DataMem_Ready};
  assign be_s  = {bus3.BusError, bus1.BusError, bus0.BusError};
  assign rd_s[0] = bus0.MReadData;
  assign rd_s[1] = bus1.MReadData;
  assign rd_s[2] = bus3.MReadData;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));
  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset(reset), .bus(bus3.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int ws_of(input int d);
    return (d == D0) ? 0 : ((d == D1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic reset_state_checks();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ready_dut%0d", k), {31'd0, rdy_s[k]}, 32'd0);
      chk($sformatf("reset_buserror_dut%0d", k), {31'd0, be_s[k]}, 32'd0);
      chk($sformatf("reset_rdata_dut%0d", k), rd_s[k], 32'd0);
    end
  endtask

  // One request held until its ready pulse; expected response queued at issue.
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] we, input logic re,
                     input logic [31:0] erd, input logic ebe);
    exp_t e;
    int   n;
    @(negedge clock);
    sel = d; addr_s = a; wdata_s = wd; we_s = we; re_s = re;
    e.dut = d; e.cyc = cyc + 2 + ws_of(d); e.rd = erd; e.be = ebe;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rdy_s[d] && n < 40);
    if (!rdy_s[d]) chk("ready_timeout", {31'd0, rdy_s[d]}, 32'd1);
    we_s = 4'b0000; re_s = 1'b0;
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clock);
      if (hold_pend) begin
        chk("rdata_hold_after_ready", rd_s[hold_dut], hold_val);
        hold_pend = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (be_s[k] && !rdy_s[k]) begin
          chk($sformatf("buserror_without_ready_dut%0d", k), {31'd0, be_s[k]}, 32'd0);
        end
        if (rdy_s[k]) begin
          if (sb.size() == 0 || sb[0].dut != k) begin
            chk($sformatf("spurious_ready_dut%0d", k), {31'd0, rdy_s[k]}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("ready_latency_dut%0d", k), 32'(cyc), 32'(e.cyc));
            chk($sformatf("buserror_dut%0d", k), {31'd0, be_s[k]}, {31'd0, e.be});
            chk($sformatf("rdata_dut%0d", k), rd_s[k], e.rd);
            hold_pend = 1'b1; hold_dut = k; hold_val = e.rd;
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    exp_t e;
    reset_state_checks();
    // Write then read back with one wait state.
    req(D1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000, 1'b0);
    req(D1, 32'h0000_0040, 32'h0000_0000, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0);
    // Byte merge with garbage in disabled lanes.
    req(D1, 32'h0000_0044, 32'h1122_3344, 4'b1111, 1'b0, 32'hDEAD_BEEF, 1'b0);
    req(D1, 32'h0000_0044, 32'hAA5A_5A5A, 4'b1000, 1'b0, 32'hDEAD_BEEF, 1'b0);
    req(D1, 32'h0000_0044, 32'h5A5A_BB5A, 4'b0010, 1'b0, 32'hDEAD_BEEF, 1'b0);
    req(D1, 32'h0000_0044, 32'h0000_0000, 4'b0000, 1'b1, 32'hAA22_BB44, 1'b0);
    // Top in-range word, byte offset bits ignored.
    req(D1, 32'h0000_0FFC, 32'h7654_3210, 4'b1111, 1'b0, 32'hAA22_BB44, 1'b0);
    req(D1, 32'h0000_0FFF, 32'h0000_0000, 4'b0000, 1'b1, 32'h7654_3210, 1'b0);
    // Out of range accesses must not alias onto word 0.
    req(D1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h7654_3210, 1'b0);
    req(D1, 32'h0000_1000, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000, 1'b1);
    req(D1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0000_0000, 1'b1);
    req(D1, 32'h8000_0000, 32'h0000_0000, 4'b0000, 1'b1, 32'h0000_0000, 1'b1);
    req(D1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0);
    // Read and write together: write wins, read data unchanged.
    req(D1, 32'h0000_0000, 32'h1234_5678, 4'b0011, 1'b1, 32'hCAFE_F00D, 1'b0);
    req(D1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b1, 32'hCAFE_5678, 1'b0);

    // Zero wait states, then a read held for six cycles: two acceptances.
    req(D0, 32'h0000_0010, 32'h0102_0304, 4'b1111, 1'b0, 32'h0000_0000, 1'b0);
    @(negedge clock);
    sel = D0; addr_s = 32'h0000_0010; we_s = 4'b0000; re_s = 1'b1;
    e.dut = D0; e.rd = 32'h0102_0304; e.be = 1'b0;
    e.cyc = cyc + 2; sb.push_back(e);
    e.cyc = cyc + 5; sb.push_back(e);
    repeat (6) @(negedge clock);
    re_s = 1'b0;
    repeat (3) @(negedge clock);

    // Reset while a three-wait-state write sits in BUSY discards it.
    req(D3, 32'h0000_0008, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0000_0000, 1'b0);
    @(negedge clock);
    sel = D3; addr_s = 32'h0000_0008; wdata_s = 32'h5555_5555; we_s = 4'b1111; re_s = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    we_s = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    reset_state_checks();
    req(D3, 32'h0000_0008, 32'h0000_0000, 4'b0000, 1'b1, 32'h0BAD_F00D, 1'b0);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; sel = D1; addr_s = 32'd0; wdata_s = 32'd0; we_s = 4'd0; re_s = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    fork
      stimulus();
      monitor_loop();
    join_any
    disable fork;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
